// File: rtl/event_repeat_ctrl_pkg.sv
// Shared types for the event repeat controller.
// Edge-kind and FSM state encodings plus the edge match helper.
package event_repeat_pkg;

  typedef enum logic [1:0] {
    ANY   = 2'b00,
    POS   = 2'b01,
    NEG   = 2'b10,
    NEVER = 2'b11
  } edge_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic edge_hit(
    input edge_sel_e s,
    input logic      p,
    input logic      n,
    input logic      a
  );
    logic h;
    h = 1'b0;
    unique case (s)
      ANY:   h = a;
      POS:   h = p;
      NEG:   h = n;
      NEVER: h = 1'b0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/event_repeat_ctrl_if.sv
// Control/status bundle between the repeat controller and its user.
// master drives the request side, slave is the controller.
interface event_repeat_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             x;
  logic             iff_en;
  logic [1:0]       edge_sel;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] remaining;
  logic             event_o;
  logic             done;
  logic             timeout;

  modport master (
    output x, iff_en, edge_sel,
    output start, count, abort,
    input  busy, remaining,
    input  event_o, done, timeout
  );

  modport slave (
    input  x, iff_en, edge_sel,
    input  start, count, abort,
    output busy, remaining,
    output event_o, done, timeout
  );

endinterface

// File: rtl/event_repeat_ctrl_edge_detect.sv
// Edge detector: one-cycle history of x and raw edge flags.
// Flags are combinational against the registered previous value.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic pos,
  output logic neg,
  output logic any
);

  logic x_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= 1'b0;
    end else begin
      x_q <= x;
    end
  end

  assign pos = x & ~x_q;
  assign neg = ~x & x_q;
  assign any = x ^ x_q;

endmodule

// File: rtl/event_repeat_ctrl.sv
// Counts qualified edges on x, then pulses done.
// Optional WAIT watchdog: define EVENT_REPEAT_CTRL_TIMEOUT_EN.
module event_repeat_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                clk,
  input logic                rst_n,
  event_repeat_ctrl_if.slave bus
);

  import event_repeat_pkg::*;

  state_e           state;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] rem_q;

  logic pos;
  logic neg;
  logic any;
  logic qual;
  logic ev;
  logic tmo;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (bus.x),
    .pos   (pos),
    .neg   (neg),
    .any   (any)
  );

  assign qual = (state == WAIT)
              && bus.iff_en
              && edge_hit(edge_sel_e'(bus.edge_sel),
                          pos, neg, any);

  // abort wins over a coincident edge
  assign ev = qual && !bus.abort;

`ifdef EVENT_REPEAT_CTRL_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state != WAIT || qual) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tmo = (state == WAIT)
             && !bus.abort
             && !qual
             && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              state  <= ARM;
              busy_q <= 1'b1;
              rem_q  <= bus.count;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        ARM: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rem_q  <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.abort || tmo) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rem_q  <= '0;
          end else if (qual) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          rem_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;
  assign bus.event_o   = ev;
  assign bus.timeout   = tmo;

endmodule

// File: tb/tb_event_repeat_ctrl.sv
// Bench for event_repeat_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_event_repeat_ctrl;

  localparam int CW = 8;
  localparam int TC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  event_repeat_ctrl_if #(.CNT_W(CW)) bus ();

  event_repeat_ctrl #(
    .CNT_W       (CW),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 arm, 2 wait, 3 done
  int ms   = 0;
  int mrem = 0;
  int mt   = 0;
  bit mxq  = 1'b0;

  int nev, ndone, nbusy, ntmo;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit hit(input bit p, input bit xv,
                             input bit [1:0] s);
    case (s)
      2'd0:    return p != xv;
      2'd1:    return !p && xv;
      2'd2:    return p && !xv;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clr();
    nev = 0; ndone = 0; nbusy = 0; ntmo = 0;
  endtask

  task automatic step(
    input bit       xi,
    input bit       ii,
    input bit [1:0] si,
    input bit       st,
    input int       cn,
    input bit       ab,
    input bit       rn
  );
    bit eev, etmo;
    @(negedge clk);
    bus.x = xi;
    bus.iff_en = ii;
    bus.edge_sel = si;
    bus.start = st;
    bus.count = CW'(cn);
    bus.abort = ab;
    rst_n = rn;
    #1;
    eev = (ms == 2) && ii && !ab && hit(mxq, xi, si);
    etmo = 1'b0;
`ifdef EVENT_REPEAT_CTRL_TIMEOUT_EN
    etmo = (ms == 2) && !ab && !eev && (mt == TC - 1);
`endif
    check("busy", 32'(bus.busy), 32'(ms == 1 || ms == 2));
    check("done", 32'(bus.done), 32'(ms == 3));
    check("remaining", 32'(bus.remaining), mrem);
    check("event_o", 32'(bus.event_o), 32'(eev));
    check("timeout", 32'(bus.timeout), 32'(etmo));
    nev   += int'(bus.event_o);
    ndone += int'(bus.done);
    nbusy += int'(bus.busy);
    ntmo  += int'(bus.timeout);
    @(posedge clk);
    if (!rn) begin
      ms = 0; mrem = 0; mt = 0;
    end else begin
      case (ms)
        0: if (st) begin
             if (cn != 0) begin ms = 1; mrem = cn; end
             else ms = 3;
           end
        1: if (ab) begin ms = 0; mrem = 0; end
           else begin ms = 2; mt = 0; end
        2: if (ab) begin ms = 0; mrem = 0; end
           else if (eev) begin
             mt = 0;
             if (mrem == 1) ms = 3;
             mrem--;
           end else if (etmo) begin ms = 0; mrem = 0; end
           else mt++;
        default: begin ms = 0; mrem = 0; end
      endcase
    end
    mxq = rn ? xi : 1'b0;
  endtask

  task automatic idle(input int n, input bit xi);
    for (int i = 0; i < n; i++) step(xi, 1, 2'd1, 0, 0, 0, 1);
  endtask

  initial begin
    bus.x = 0; bus.iff_en = 0; bus.edge_sel = 0;
    bus.start = 0; bus.count = 0; bus.abort = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    idle(2, 0);

    // rising edges only, three of them
    clr();
    step(0, 1, 2'd1, 1, 3, 0, 1);
    for (int i = 0; i < 16; i++) step(((i / 2) % 2) == 1, 1, 2'd1, 0, 0, 0, 1);
    check("s030_events", nev, 3);
    check("s030_done", ndone, 1);

    // zero-iteration repeat
    clr();
    step(0, 1, 2'd1, 1, 0, 0, 1);
    idle(3, 0);
    check("s031_done", ndone, 1);
    check("s031_busy", nbusy, 0);
    check("s031_events", nev, 0);

    // any-change with an unqualified first change
    clr();
    step(0, 1, 2'd0, 1, 2, 0, 1);
    step(0, 1, 2'd0, 0, 0, 0, 1);
    step(1, 0, 2'd0, 0, 0, 0, 1);
    step(1, 1, 2'd0, 0, 0, 0, 1);
    step(0, 1, 2'd0, 0, 0, 0, 1);
    step(0, 1, 2'd0, 0, 0, 0, 1);
    step(1, 1, 2'd0, 0, 0, 0, 1);
    idle(2, 1);
    check("s032_events", nev, 2);
    check("s032_done", ndone, 1);

    // edge during ARM is only the baseline
    idle(1, 0);
    clr();
    step(0, 1, 2'd1, 1, 3, 0, 1);
    step(1, 1, 2'd1, 0, 0, 0, 1);
    #1;
    check("s033_rem", 32'(bus.remaining), 3);
    check("s033_busy", 32'(bus.busy), 1);
    step(1, 1, 2'd1, 0, 0, 0, 1);
    check("s033_events", nev, 0);
    step(1, 1, 2'd1, 0, 0, 1, 1);
    idle(1, 0);

    // abort against final edge, then reset mid-WAIT
    clr();
    step(0, 1, 2'd1, 1, 1, 0, 1);
    step(0, 1, 2'd1, 0, 0, 0, 1);
    step(1, 1, 2'd1, 0, 0, 1, 1);
    idle(3, 1);
    step(0, 1, 2'd1, 1, 2, 0, 1);
    step(0, 1, 2'd1, 0, 0, 0, 1);
    step(1, 1, 2'd1, 0, 0, 0, 1);
    step(1, 1, 2'd1, 0, 0, 0, 0);
    idle(3, 0);
    check("s034_done", ndone, 0);
    check("s034_events", nev, 1);
    check("s034_rem", 32'(bus.remaining), 0);

`ifdef EVENT_REPEAT_CTRL_TIMEOUT_EN
    clr();
    step(0, 1, 2'd3, 1, 2, 0, 1);
    step(0, 1, 2'd3, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(i % 2 == 1, 1, 2'd3, 0, 0, 0, 1);
    check("s035_timeout", ntmo, 1);
    check("s035_done", ndone, 0);
    check("s035_busy", 32'(bus.busy), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 4)),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
